// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: decodes and checks a request, runs one valid/ready
// transaction on the data memory, and returns extended load data or an error code.
module load_store_unit #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_rdata,
   output logic [1:0]        resp_err,
   output logic              busy,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_write,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wstrb,
   input  logic [XLEN-1:0]   mem_rdata
);
   localparam int SW   = XLEN / 8;
   localparam int OFFW = $clog2(SW);

   // Handshakes: a request transfers on an edge where req_valid & req_ready; a memory
   // access completes on an edge where mem_valid & mem_ready; a response is consumed on
   // an edge where resp_valid & resp_ready. Each valid is held with its payload stable.
   typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;
   state_t state;

   logic [2:0]      r_funct3;
   logic [OFFW-1:0] r_off;
   logic [31:0]     cnt;

   logic [OFFW-1:0] off;
   logic [2:0]      off3;
   logic            illegal;
   logic            misaligned;
   logic [SW-1:0]   strb_mask;
   logic [SW-1:0]   strb;
   logic [XLEN-1:0] wrep;
   logic [XLEN-1:0] lane;
   logic [XLEN-1:0] ext;

   assign req_ready  = (state == IDLE);
   assign busy       = (state != IDLE);
   assign mem_valid  = (state == MEM);
   assign resp_valid = (state == RESP);

   always_comb begin
      off     = req_addr[OFFW-1:0];
      off3    = 3'(off);
      illegal = (req_funct3 == 3'b111) || (req_write && req_funct3[2]) ||
                ((XLEN == 32) && (req_funct3 == 3'b011 || req_funct3 == 3'b110));
      case (req_funct3[1:0])
         2'd1:    misaligned = off3[0];
         2'd2:    misaligned = (off3[1:0] != 2'b00);
         2'd3:    misaligned = (off3 != 3'b000);
         default: misaligned = 1'b0;
      endcase
      case (req_funct3[1:0])
         2'd0:    strb_mask = SW'(1);
         2'd1:    strb_mask = SW'(3);
         2'd2:    strb_mask = SW'(15);
         default: strb_mask = '1;
      endcase
      strb = strb_mask << off;
      case (req_funct3[1:0])
         2'd0:    wrep = {SW{req_wdata[7:0]}};
         2'd1:    wrep = {(XLEN/16){req_wdata[15:0]}};
         2'd2:    wrep = {(XLEN/32){req_wdata[31:0]}};
         default: wrep = req_wdata;
      endcase
   end

   // Load lane is taken from the captured byte offset, not the word-aligned address.
   always_comb begin
      lane = mem_rdata >> {r_off, 3'b000};
      case (r_funct3)
         3'b000:  ext = XLEN'({{XLEN{lane[7]}}, lane[7:0]});
         3'b001:  ext = XLEN'({{XLEN{lane[15]}}, lane[15:0]});
         3'b010:  ext = XLEN'({{XLEN{lane[31]}}, lane[31:0]});
         3'b100:  ext = XLEN'(lane[7:0]);
         3'b101:  ext = XLEN'(lane[15:0]);
         3'b110:  ext = XLEN'(lane[31:0]);
         default: ext = lane;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         r_funct3   <= '0;
         r_off      <= '0;
         cnt        <= '0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= '0;
         resp_rdata <= '0;
         resp_err   <= 2'b00;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               r_funct3   <= req_funct3;
               r_off      <= off;
               cnt        <= '0;
               mem_write  <= req_write;
               mem_addr   <= req_addr & ~XLEN'(SW - 1);
               mem_wdata  <= wrep;
               mem_wstrb  <= req_write ? strb : '0;
               resp_rdata <= '0;
               if (illegal) begin
                  resp_err <= 2'b10;
                  state    <= RESP;
               end else if (misaligned) begin
                  resp_err <= 2'b01;
                  state    <= RESP;
               end else begin
                  resp_err <= 2'b00;
                  state    <= MEM;
               end
            end
            MEM: begin
               // Completion wins over a timeout landing in the same cycle.
               if (mem_ready) begin
                  state      <= RESP;
                  cnt        <= '0;
                  resp_err   <= 2'b00;
                  resp_rdata <= mem_write ? '0 : ext;
               end else if (TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1)) begin
                  state      <= RESP;
                  cnt        <= '0;
                  resp_err   <= 2'b11;
                  resp_rdata <= '0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            RESP: if (resp_ready) begin
               state      <= IDLE;
               resp_rdata <= '0;
               resp_err   <= 2'b00;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 32-bit instance (TIMEOUT=4) and a 64-bit instance,
// directed vectors with hand-computed responses checked through expected queues.
module tb_load_store_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic        busy, mem_valid, mem_ready, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   logic        w_req_valid, w_req_ready, w_req_write;
   logic [2:0]  w_req_funct3;
   logic [63:0] w_req_addr, w_req_wdata;
   logic        w_resp_valid, w_resp_ready;
   logic [63:0] w_resp_rdata;
   logic [1:0]  w_resp_err;
   logic        w_busy, w_mem_valid, w_mem_ready, w_mem_write;
   logic [63:0] w_mem_addr, w_mem_wdata, w_mem_rdata;
   logic [7:0]  w_mem_wstrb;

   load_store_unit #(.XLEN(32), .TIMEOUT(4)) u32 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata));

   load_store_unit #(.XLEN(64), .TIMEOUT(64)) u64 (
      .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_ready(w_req_ready),
      .req_write(w_req_write), .req_funct3(w_req_funct3), .req_addr(w_req_addr),
      .req_wdata(w_req_wdata), .resp_valid(w_resp_valid), .resp_ready(w_resp_ready),
      .resp_rdata(w_resp_rdata), .resp_err(w_resp_err), .busy(w_busy),
      .mem_valid(w_mem_valid), .mem_ready(w_mem_ready), .mem_write(w_mem_write),
      .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_wstrb(w_mem_wstrb),
      .mem_rdata(w_mem_rdata));

   int n_tests = 0;
   int n_fail  = 0;
   logic [33:0] exp_q[$];
   logic [65:0] exp64_q[$];
   logic [33:0] e32;
   logic [65:0] e64;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitors: pop one expected response per accepted DUT response.
   always @(negedge clk) begin
      if (!rst && resp_valid && resp_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp32_unexpected: got rdata 0x%0h err %0d with empty queue", resp_rdata, resp_err);
         end else begin
            e32 = exp_q.pop_front();
            chk("resp32_rdata", 64'(resp_rdata), 64'(e32[31:0]));
            chk("resp32_err", 64'(resp_err), 64'(e32[33:32]));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && w_resp_valid && w_resp_ready) begin
         if (exp64_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp64_unexpected: got rdata 0x%0h err %0d with empty queue", w_resp_rdata, w_resp_err);
         end else begin
            e64 = exp64_q.pop_front();
            chk("resp64_rdata", w_resp_rdata, e64[63:0]);
            chk("resp64_err", 64'(w_resp_err), 64'(e64[65:64]));
         end
      end
   end

   // mdelay: cycles mem_ready stays low; >= 4 means never (timeout expected).
   task automatic run32(input string name, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int mdelay, input int rdelay,
                        input logic exp_mem, input logic [31:0] e_maddr,
                        input logic [31:0] e_wdata, input logic [3:0] e_strb,
                        input logic [31:0] e_rdata, input logic [1:0] e_err);
      int hold;
      hold = (mdelay < 4) ? mdelay : 4;
      exp_q.push_back({e_err, e_rdata});
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      chk({name, "_req_ready"}, 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      if (exp_mem) begin
         for (int d = 0; d <= hold; d++) begin
            if (d == hold && mdelay >= 4) begin
               chk({name, "_timeout_mem_valid"}, 64'(mem_valid), 64'd0);
            end else begin
               chk({name, "_mem_valid"}, 64'(mem_valid), 64'd1);
               chk({name, "_mem_addr"}, 64'(mem_addr), 64'(e_maddr));
               chk({name, "_mem_wstrb"}, 64'(mem_wstrb), 64'(e_strb));
               chk({name, "_mem_write"}, 64'(mem_write), 64'(wr));
               if (wr) chk({name, "_mem_wdata"}, 64'(mem_wdata), 64'(e_wdata));
               chk({name, "_busy_mem"}, 64'(busy), 64'd1);
               chk({name, "_no_early_resp"}, 64'(resp_valid), 64'd0);
               if (d == hold) begin
                  mem_ready = 1'b1;
                  mem_rdata = rdata;
               end
               @(posedge clk); #1;
               mem_ready = 1'b0;
               @(negedge clk);
            end
         end
      end else begin
         chk({name, "_no_mem_valid"}, 64'(mem_valid), 64'd0);
      end
      for (int r = 0; r <= rdelay; r++) begin
         chk({name, "_resp_valid"}, 64'(resp_valid), 64'd1);
         chk({name, "_resp_hold"}, 64'(resp_rdata), 64'(e_rdata));
         chk({name, "_busy_resp"}, 64'(busy), 64'd1);
         chk({name, "_no_accept_resp"}, 64'(req_ready), 64'd0);
         if (r < rdelay) @(negedge clk);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      resp_ready = 1'b0;
      @(negedge clk);
      chk({name, "_idle_after"}, 64'(req_ready), 64'd1);
      chk({name, "_resp_dropped"}, 64'(resp_valid), 64'd0);
   endtask

   task automatic run64(input string name, input logic wr, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] rdata, input logic [63:0] e_maddr,
                        input logic [63:0] e_wdata, input logic [7:0] e_strb,
                        input logic [63:0] e_rdata);
      exp64_q.push_back({2'b00, e_rdata});
      @(posedge clk); #1;
      w_req_valid = 1'b1; w_req_write = wr; w_req_funct3 = f3; w_req_addr = addr; w_req_wdata = wdata;
      @(posedge clk); #1;
      w_req_valid = 1'b0;
      @(negedge clk);
      chk({name, "_mem_valid"}, 64'(w_mem_valid), 64'd1);
      chk({name, "_mem_addr"}, w_mem_addr, e_maddr);
      chk({name, "_mem_wstrb"}, 64'(w_mem_wstrb), 64'(e_strb));
      if (wr) chk({name, "_mem_wdata"}, w_mem_wdata, e_wdata);
      w_mem_ready = 1'b1;
      w_mem_rdata = rdata;
      @(posedge clk); #1;
      w_mem_ready  = 1'b0;
      w_resp_ready = 1'b1;
      @(negedge clk);
      chk({name, "_resp_valid"}, 64'(w_resp_valid), 64'd1);
      @(posedge clk); #1;
      w_resp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
      resp_ready = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
      w_req_valid = 1'b0; w_req_write = 1'b0; w_req_funct3 = '0; w_req_addr = '0; w_req_wdata = '0;
      w_resp_ready = 1'b0; w_mem_ready = 1'b0; w_mem_rdata = '0;
      #2;
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mem_valid", 64'(mem_valid), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
      chk("rst_resp_err", 64'(resp_err), 64'd0);
      chk("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst64_req_ready", 64'(w_req_ready), 64'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      //    name     wr    f3      addr          wdata         rdata         md rd mem   maddr         wdata         strb     rdata         err
      run32("lb",    1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8000_0000, 0, 0, 1'b1, 32'h0000_0100, 32'h0,        4'b0000, 32'hFFFF_FF80, 2'b00);
      run32("lhu",   1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'hBEEF_1234, 0, 0, 1'b1, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_BEEF, 2'b00);
      run32("sh",    1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        0, 0, 1'b1, 32'h0000_0200, 32'hABCD_ABCD, 4'b1100, 32'h0,        2'b00);
      run32("lw_mis",1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 0, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        2'b01);
      run32("sw_ill",1'b1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        2'b10);
      run32("lw_to", 1'b0, 3'b010, 32'h0000_0300, 32'h0,        32'h0,        9, 0, 1'b1, 32'h0000_0300, 32'h0,        4'b0000, 32'h0,        2'b11);
      run32("sw_dly",1'b1, 3'b010, 32'h0000_0404, 32'hDEAD_BEEF, 32'h0,        3, 2, 1'b1, 32'h0000_0404, 32'hDEAD_BEEF, 4'b1111, 32'h0,        2'b00);
      run32("sb",    1'b1, 3'b000, 32'h0000_0001, 32'h0000_005A, 32'h0,        1, 0, 1'b1, 32'h0000_0000, 32'h5A5A_5A5A, 4'b0010, 32'h0,        2'b00);
      run32("lh",    1'b0, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_0000, 2, 1, 1'b1, 32'h0000_0000, 32'h0,        4'b0000, 32'hFFFF_8001, 2'b00);
      run32("ld32",  1'b0, 3'b011, 32'h0000_0003, 32'h0,        32'h0,        0, 0, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        2'b10);
      run32("lbu",   1'b0, 3'b100, 32'h0000_0007, 32'h0,        32'h9A00_0000, 0, 0, 1'b1, 32'h0000_0004, 32'h0,        4'b0000, 32'h0000_009A, 2'b00);
      run32("f111",  1'b0, 3'b111, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        2'b10);
      run32("sh_mis",1'b1, 3'b001, 32'h0000_0001, 32'h0000_1111, 32'h0,        0, 0, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        2'b01);

      // Reset in the middle of a memory access: no response may follow.
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("rstmid_mem_valid_before", 64'(mem_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_mem_valid_drop", 64'(mem_valid), 64'd0);
      chk("rstmid_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      resp_ready = 1'b1;
      mem_ready  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rstmid_req_ready", 64'(req_ready), 64'd1);
         chk("rstmid_no_resp", 64'(resp_valid), 64'd0);
         chk("rstmid_no_mem", 64'(mem_valid), 64'd0);
      end
      @(posedge clk); #1;
      resp_ready = 1'b0;
      mem_ready  = 1'b0;

      run64("lwu64", 1'b0, 3'b110, 64'h4,  64'h0, 64'hF000_0000_0000_0000, 64'h0,  64'h0, 8'h00, 64'h0000_0000_F000_0000);
      run64("sd64",  1'b1, 3'b011, 64'h8,  64'h1122_3344_5566_7788, 64'h0, 64'h8, 64'h1122_3344_5566_7788, 8'hFF, 64'h0);
      run64("lw64",  1'b0, 3'b010, 64'h4,  64'h0, 64'h8000_0000_0000_0000, 64'h0,  64'h0, 8'h00, 64'hFFFF_FFFF_8000_0000);
      run64("ld64",  1'b0, 3'b011, 64'h10, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h10, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF);
      run64("sb64",  1'b1, 3'b000, 64'hF,  64'hAB, 64'h0, 64'h8, 64'hABAB_ABAB_ABAB_ABAB, 8'h80, 64'h0);

      repeat (3) @(negedge clk);
      chk("queue32_drained", 64'(exp_q.size()), 64'd0);
      chk("queue64_drained", 64'(exp64_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
